uart_receiver: RTL and testbench

UART receive stage, the downstream counterpart of the transmitter. It samples the serial RX line using the shared 16x-oversampling baud tick from the baud-rate generator and deframes start, data, optional parity and stop bits. Each received word is presented with a one-cycle RX_DONE pulse, suitable as the write enable of the RX FIFO. The block also reports parity and framing errors for each word.

---
 rtl/uart_receiver.sv | 176 +++++++++++++++++
 tb/tb_uart_receiver.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// UART receive deframer: 16x-oversampled start/data/parity/stop with per-word error flags.
// Define UART_RX_SYNC_EN to pass RX through a two-flop synchronizer (adds 2 CLK latency).
module uart_receiver #(
   parameter int DATA_WIDTH     = 8,
   parameter int STOP_BIT_TICKS = 16
) (
   input  logic                          CLK,
   input  logic                          RESET,
   input  logic                          PARITY_EN,
   input  logic                          PARITY_MODE,
   input  logic                          RX_BR_TICKS,
   input  logic                          RX,
   output logic [DATA_WIDTH-1:0]         RX_DATA_OUT,
   output logic                          RX_DONE,
   output logic                          PARITY_ERR,
   output logic                          FRAME_ERR,
   output logic [2:0]                    State_dpg,
   output logic [$clog2(DATA_WIDTH)-1:0] bit_idx_dpg
);

   localparam int SW = $clog2(STOP_BIT_TICKS);
   localparam int NW = $clog2(DATA_WIDTH);
   localparam logic [SW-1:0] S_MID  = SW'(7);
   localparam logic [SW-1:0] S_BIT  = SW'(15);
   localparam logic [SW-1:0] S_STOP = SW'(STOP_BIT_TICKS - 1);
   localparam logic [NW-1:0] N_LAST = NW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'b000,
      START  = 3'b001,
      DATA   = 3'b010,
      PARITY = 3'b011,
      STOP   = 3'b100
   } state_t;

   state_t                state_q, state_d;
   logic [SW-1:0]         s_q, s_d;
   logic [NW-1:0]         n_q, n_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  perr_q, perr_d;
   logic                  mode_q, mode_d;
   logic                  stop_q, stop_d;
   logic                  pend_q, pend_d;
   logic                  rx_s;

`ifdef UART_RX_SYNC_EN
   logic [1:0] sync_q;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) sync_q <= '1;
      else        sync_q <= {sync_q[0], RX};
   end

   assign rx_s = sync_q[1];
`else
   assign rx_s = RX;
`endif

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      n_d     = n_q;
      shift_d = shift_q;
      perr_d  = perr_q;
      mode_d  = mode_q;
      stop_d  = stop_q;
      pend_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!rx_s) begin
               s_d     = '0;
               state_d = START;
            end
         end
         START: begin
            if (RX_BR_TICKS) begin
               if (s_q == S_MID) begin
                  if (!rx_s) begin
                     s_d     = '0;
                     n_d     = '0;
                     state_d = DATA;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  s_d = s_q + SW'(1);
               end
            end
         end
         DATA: begin
            if (RX_BR_TICKS) begin
               if (s_q == S_BIT) begin
                  shift_d = {rx_s, shift_q[DATA_WIDTH-1:1]};
                  s_d     = '0;
                  if (n_q == N_LAST) begin
                     // parity config is latched here so later changes cannot affect this frame
                     perr_d  = 1'b0;
                     mode_d  = PARITY_MODE;
                     state_d = PARITY_EN ? PARITY : STOP;
                  end else begin
                     n_d = n_q + NW'(1);
                  end
               end else begin
                  s_d = s_q + SW'(1);
               end
            end
         end
         PARITY: begin
            if (RX_BR_TICKS) begin
               if (s_q == S_BIT) begin
                  perr_d  = rx_s ^ (^shift_q) ^ mode_q;
                  s_d     = '0;
                  state_d = STOP;
               end else begin
                  s_d = s_q + SW'(1);
               end
            end
         end
         STOP: begin
            if (RX_BR_TICKS) begin
               if (s_q == S_STOP) begin
                  stop_d  = rx_s;
                  pend_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  s_d = s_q + SW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q <= IDLE;
         s_q     <= '0;
         n_q     <= '0;
         shift_q <= '0;
         perr_q  <= 1'b0;
         mode_q  <= 1'b0;
         stop_q  <= 1'b1;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         n_q     <= n_d;
         shift_q <= shift_d;
         perr_q  <= perr_d;
         mode_q  <= mode_d;
         stop_q  <= stop_d;
         pend_q  <= pend_d;
      end
   end

   // word is published one CLK after the stop decision, leaving the FSM free to catch a new start bit
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         RX_DATA_OUT <= '0;
         RX_DONE     <= 1'b0;
         PARITY_ERR  <= 1'b0;
         FRAME_ERR   <= 1'b0;
      end else begin
         RX_DONE <= pend_q;
         if (pend_q) begin
            RX_DATA_OUT <= shift_q;
            PARITY_ERR  <= perr_q;
            FRAME_ERR   <= ~stop_q;
         end
      end
   end

   assign State_dpg   = state_q;
   assign bit_idx_dpg = n_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: clean, parity, framing, glitch and mid-frame reset cases.
module tb_uart_receiver;

   localparam int DW       = 8;
   localparam int TDIV     = 4;
   localparam int BIT_CLKS = 16 * TDIV;

   logic          clk      = 1'b0;
   logic          rst_n    = 1'b0;
   logic          par_en   = 1'b0;
   logic          par_mode = 1'b0;
   logic          tick     = 1'b0;
   logic          rx       = 1'b1;
   logic [DW-1:0] rx_data;
   logic          rx_done;
   logic          perr;
   logic          ferr;
   logic [2:0]    state_dbg;
   logic [2:0]    idx_dbg;

   int unsigned   n_cmp    = 0;
   int unsigned   n_bad    = 0;
   int unsigned   done_cnt = 0;
   int unsigned   base;
   logic [DW-1:0] cap_data = '0;
   logic          cap_perr = 1'b0;
   logic          cap_ferr = 1'b0;
   logic [2:0]    st_h1    = 3'd0;
   logic [2:0]    st_h2    = 3'd0;
   bit            found;

   uart_receiver #(.DATA_WIDTH(DW), .STOP_BIT_TICKS(16)) dut (
      .CLK        (clk),
      .RESET      (rst_n),
      .PARITY_EN  (par_en),
      .PARITY_MODE(par_mode),
      .RX_BR_TICKS(tick),
      .RX         (rx),
      .RX_DATA_OUT(rx_data),
      .RX_DONE    (rx_done),
      .PARITY_ERR (perr),
      .FRAME_ERR  (ferr),
      .State_dpg  (state_dbg),
      .bit_idx_dpg(idx_dbg)
   );

   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   initial begin
      forever begin
         repeat (TDIV - 1) @(negedge clk);
         tick = 1'b1;
         @(negedge clk);
         tick = 1'b0;
      end
   end

   // capture each word; done must follow exactly one CLK after the FSM left STOP
   initial begin
      forever begin
         @(negedge clk);
         if (rx_done) begin
            done_cnt++;
            cap_data = rx_data;
            cap_perr = perr;
            cap_ferr = ferr;
            check("done_lat", {26'd0, st_h2, st_h1}, {26'd0, 3'd4, 3'd0});
         end
         st_h2 = st_h1;
         st_h1 = state_dbg;
      end
   end

   task automatic drive_bit(input logic b, input int clks);
      rx = b;
      repeat (clks) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic with_par, input logic par_bit,
                             input logic stop_bit, input int stop_clks);
      drive_bit(1'b0, BIT_CLKS);
      for (int i = 0; i < DW; i++) drive_bit(d[i], BIT_CLKS);
      if (with_par) drive_bit(par_bit, BIT_CLKS);
      drive_bit(stop_bit, stop_clks);
      rx = 1'b1;
   endtask

   task automatic expect_word(input string tag, input int unsigned cnt0, input logic [7:0] d,
                              input logic pe, input logic fe);
      check({tag, "_cnt"},  done_cnt, cnt0 + 1);
      check({tag, "_data"}, cap_data, d);
      check({tag, "_perr"}, cap_perr, pe);
      check({tag, "_ferr"}, cap_ferr, fe);
   endtask

   initial begin
      repeat (5) @(negedge clk);
      check("rst_data",  rx_data,   0);
      check("rst_done",  rx_done,   0);
      check("rst_perr",  perr,      0);
      check("rst_ferr",  ferr,      0);
      check("rst_state", state_dbg, 0);
      check("rst_idx",   idx_dbg,   0);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);

      // back-to-back clean frames, no parity
      base = done_cnt;
      send_frame(8'h55, 1'b0, 1'b0, 1'b1, BIT_CLKS);
      expect_word("w55", base, 8'h55, 1'b0, 1'b0);
      base = done_cnt;
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1, BIT_CLKS);
      expect_word("wA5", base, 8'hA5, 1'b0, 1'b0);

      // even parity: 0xA5 has four ones
      par_en = 1'b1; par_mode = 1'b0;
      base = done_cnt;
      send_frame(8'hA5, 1'b1, 1'b0, 1'b1, BIT_CLKS);
      expect_word("evn_ok", base, 8'hA5, 1'b0, 1'b0);
      base = done_cnt;
      send_frame(8'hA5, 1'b1, 1'b1, 1'b1, BIT_CLKS);
      expect_word("evn_bad", base, 8'hA5, 1'b1, 1'b0);

      // odd parity: 0x03 has two ones, parity bit must be 1
      par_mode = 1'b1;
      base = done_cnt;
      send_frame(8'h03, 1'b1, 1'b1, 1'b1, BIT_CLKS);
      expect_word("odd_ok", base, 8'h03, 1'b0, 1'b0);
      base = done_cnt;
      send_frame(8'h03, 1'b1, 1'b0, 1'b1, BIT_CLKS);
      expect_word("odd_bad", base, 8'h03, 1'b1, 1'b0);

      // stop bit low; the line stays low briefly so the receiver re-enters START then aborts
      par_en = 1'b0;
      base = done_cnt;
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 48);
      repeat (2 * BIT_CLKS) @(negedge clk);
      expect_word("brk", base, 8'h3C, 1'b0, 1'b1);
      check("brk_idle", state_dbg, 0);
      base = done_cnt;
      send_frame(8'h81, 1'b0, 1'b0, 1'b1, BIT_CLKS);
      expect_word("w81", base, 8'h81, 1'b0, 1'b0);

      // false start: low for 3 ticks only
      base = done_cnt;
      rx = 1'b0;
      repeat (3 * TDIV) @(negedge clk);
      check("gl_start", state_dbg, 1);
      rx = 1'b1;
      repeat (2 * BIT_CLKS) @(negedge clk);
      check("gl_state", state_dbg, 0);
      check("gl_cnt",   done_cnt,  base);
      check("gl_data",  rx_data,   8'h81);
      check("gl_ferr",  ferr,      0);

      // both errors at once: even parity of 0xF0 is 0, send 1; stop low
      par_en = 1'b1; par_mode = 1'b0;
      base = done_cnt;
      send_frame(8'hF0, 1'b1, 1'b1, 1'b0, 48);
      repeat (2 * BIT_CLKS) @(negedge clk);
      expect_word("both", base, 8'hF0, 1'b1, 1'b1);

      // reset in DATA at bit index 4 of an all-ones word
      par_en = 1'b0;
      base = done_cnt;
      drive_bit(1'b0, BIT_CLKS);
      rx = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 10 * BIT_CLKS && !found; i++) begin
         if (state_dbg == 3'd2 && idx_dbg == 3'd4) found = 1'b1;
         else @(negedge clk);
      end
      check("rst_wait", found, 1);
      rst_n = 1'b0;
      @(negedge clk);
      check("mr_data",  rx_data,   0);
      check("mr_done",  rx_done,   0);
      check("mr_perr",  perr,      0);
      check("mr_ferr",  ferr,      0);
      check("mr_state", state_dbg, 0);
      check("mr_idx",   idx_dbg,   0);
      rst_n = 1'b1;
      repeat (8 * BIT_CLKS) @(negedge clk);
      check("mr_cnt", done_cnt, base);
      base = done_cnt;
      send_frame(8'h12, 1'b0, 1'b0, 1'b1, BIT_CLKS);
      expect_word("w12", base, 8'h12, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
